mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single CPU-side memory port of `memory` between two requesters: the ARMv4T core (`cpu_*`) and a DMA engine (`dma_*`).
- One transaction at a time; grants are latched; `mem_ok` is steered back to the owner only.
- DMA has priority, bounded by an anti-starvation run limit.
- A watchdog aborts transactions that never complete.
- Sits in the top level between the requesters and the memory's `mem_*` port. Top-level glue maps `mem_wdata`/`mem_rdata` onto the bidirectional data bus.

Parameters:
- DMA_RUN_MAX, 4, max consecutive DMA grants while CPU is waiting (legal range 1..15).
- TIMEOUT, 255, cycles without `mem_ok` before abort (1..255).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  32  CPU address.
- cpu_wdata  in  32  CPU write data.
- cpu_width  in  2  CPU access width (0 byte, 1 half, 2 word).
- cpu_read  in  1  CPU read request, level, held until ok/err.
- cpu_write  in  1  CPU write request, level, held until ok/err.
- cpu_rdata  out  32  read data to CPU.
- cpu_ok  out  1  one-cycle completion pulse.
- cpu_err  out  1  one-cycle error pulse.
- dma_addr, dma_wdata, dma_width, dma_read, dma_write  in  32/32/2/1/1  same meaning for DMA.
- dma_rdata  out  32  read data to DMA.
- dma_ok  out  1  one-cycle completion pulse.
- dma_err  out  1  one-cycle error pulse.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_width  out  2  memory access width.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_rdata  in  32  memory read data.
- mem_ok  in  1  memory completion.
- busy  out  1  transaction in flight.
- owner  out  1  0 = CPU, 1 = DMA; valid while busy.

Behaviour:
- States: IDLE, BUSY.
- Reset:
  - State IDLE.
  - All out strobes 0: `mem_read`, `mem_write`, `*_ok`, `*_err`, `busy`.
  - `mem_addr`/`mem_wdata`/`mem_width` = 0; `owner` = 0; run counter = 0; watchdog = 0.
  - Reset mid-transaction drops the transaction silently: no ok or err is issued.
- Arbitration in IDLE, evaluated each cycle:
  - Requester valid = read XOR write.
  - Both DMA and CPU valid: DMA wins unless run counter == DMA_RUN_MAX, in which case CPU wins.
  - Only one valid: that one wins.
- Grant:
  - Next edge enters BUSY.
  - Winner's addr/wdata/width/read/write are registered onto `mem_*`.
  - `owner` is set; watchdog is cleared.
- Run counter:
  - +1 on each DMA grant, saturating at DMA_RUN_MAX.
  - Cleared on any CPU grant.
  - Cleared whenever IDLE sees no DMA request.
- Illegal request (read and write both high) seen in IDLE:
  - Not granted; requester's err pulses next cycle; state stays IDLE.
  - If both requesters are illegal, both err pulse.
  - An illegal requester loses to a valid one; its err still pulses.
- BUSY:
  - `mem_*` outputs are held stable; requester inputs are ignored, so changes mid-transaction have no effect.
  - `owner_rdata` = `mem_rdata`, combinational pass-through.
  - `owner_ok` = `mem_ok`, combinational, same cycle; non-owner ok stays 0.
  - On `mem_ok`: next edge returns to IDLE and deasserts `mem_read`/`mem_write`.
- Timing:
  - Earliest latency is request at edge 0, strobe at edge 1.
  - After ok there is one IDLE bubble. Requesters must drop or replace their request by the edge after ok.
  - A request still high in IDLE is a new transaction.
- Watchdog:
  - Increments every BUSY cycle without `mem_ok`.
  - On reaching TIMEOUT: strobes deassert, owner's err pulses one cycle, state returns to IDLE.
  - `mem_ok` on the same cycle as the timeout takes precedence: ok is issued, no err.
- `rdata` to the non-owner, and to both requesters in IDLE, is 0.
- `busy` = (state == BUSY).

Test Plan:
- CPU word read addr 0x0300_0010 alone, `mem_ok` 3 cycles after strobe, `mem_rdata` 0xDEADBEEF -> `mem_read` high at edge 1, `cpu_ok` pulse with `cpu_rdata` 0xDEADBEEF, `dma_ok` stays 0, busy drops the cycle after ok.
- CPU and DMA request simultaneously and continuously, memory acks in 1 cycle, DMA_RUN_MAX=4 -> grant sequence D,D,D,D,C,D,D,D,D,C.
- DMA write 0x1234_5678 to 0x0600_0000, DMA changes its addr to 0x0 mid-BUSY -> `mem_addr` stays 0x0600_0000 until ok.
- CPU read with `mem_ok` never asserted, TIMEOUT=8 -> `mem_read` high 8 cycles, then `cpu_err` one-cycle pulse, no `cpu_ok`, IDLE next cycle.
- DMA asserts read and write together while CPU reads -> `dma_err` pulse, CPU granted, `mem_write` never asserted.
- Reset during BUSY (`mem_ok` never arrives) -> the cycle after reset all strobes 0, busy 0, no ok or err; a fresh CPU request is then granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single CPU-side memory port: DMA has priority
// with a bounded run length, one transaction in flight, and a watchdog abort.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int DMA_RUN_MAX = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_width,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ok,
    output logic        cpu_err,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_width,
    input  logic        dma_read,
    input  logic        dma_write,
    output logic [31:0] dma_rdata,
    output logic        dma_ok,
    output logic        dma_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_width,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ok,
    output logic        busy,
    output logic        owner
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [3:0] RUN_LIMIT  = 4'(DMA_RUN_MAX);
    localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT - 1);

    state_t      state_reg;
    logic        owner_reg;
    logic [3:0]  run_cnt_reg;
    logic [7:0]  wdog_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic [1:0]  mem_width_reg;
    logic        mem_read_reg;
    logic        mem_write_reg;
    logic [1:0]  err_reg;

    // Requester index 0 is the CPU, index 1 is the DMA engine.
    logic [1:0]  req_read;
    logic [1:0]  req_write;
    logic [1:0]  req_valid;
    logic [1:0]  req_illegal;
    logic [1:0]  ok_vec;
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [1:0]  req_width [2];
    logic [31:0] rdata_vec [2];

    assign req_read     = {dma_read, cpu_read};
    assign req_write    = {dma_write, cpu_write};
    assign req_addr[0]  = cpu_addr;
    assign req_addr[1]  = dma_addr;
    assign req_wdata[0] = cpu_wdata;
    assign req_wdata[1] = dma_wdata;
    assign req_width[0] = cpu_width;
    assign req_width[1] = dma_width;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic PORT_ID = 1'(gi);
            logic is_owner;
            assign is_owner        = (state_reg == BUSY) && (owner_reg == PORT_ID);
            assign req_valid[gi]   = req_read[gi] ^ req_write[gi];
            assign req_illegal[gi] = req_read[gi] & req_write[gi];
            assign ok_vec[gi]      = is_owner & mem_ok;
            assign rdata_vec[gi]   = is_owner ? mem_rdata : 32'd0;
        end
    endgenerate

    // DMA yields only once it has used up its run while the CPU is waiting.
    logic dma_wins;
    logic cpu_wins;
    logic win_id;
    assign dma_wins = req_valid[1] && (!req_valid[0] || (run_cnt_reg != RUN_LIMIT));
    assign cpu_wins = req_valid[0] && !dma_wins;
    assign win_id   = dma_wins;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            run_cnt_reg   <= 4'd0;
            wdog_reg      <= 8'd0;
            mem_addr_reg  <= 32'd0;
            mem_wdata_reg <= 32'd0;
            mem_width_reg <= 2'd0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            err_reg       <= 2'b00;
        end else begin
            err_reg <= 2'b00;
            if (state_reg == IDLE) begin
                err_reg <= req_illegal;
                if (!req_valid[1]) begin
                    run_cnt_reg <= 4'd0;
                end
                if (dma_wins || cpu_wins) begin
                    state_reg     <= BUSY;
                    owner_reg     <= win_id;
                    wdog_reg      <= 8'd0;
                    mem_addr_reg  <= req_addr[win_id];
                    mem_wdata_reg <= req_wdata[win_id];
                    mem_width_reg <= req_width[win_id];
                    mem_read_reg  <= req_read[win_id];
                    mem_write_reg <= req_write[win_id];
                    if (cpu_wins) begin
                        run_cnt_reg <= 4'd0;
                    end else if (run_cnt_reg != RUN_LIMIT) begin
                        run_cnt_reg <= run_cnt_reg + 4'd1;
                    end
                end
            end else begin
                // A completion on the timeout cycle wins over the abort.
                if (mem_ok) begin
                    state_reg     <= IDLE;
                    mem_read_reg  <= 1'b0;
                    mem_write_reg <= 1'b0;
                end else if (wdog_reg == WDOG_LIMIT) begin
                    state_reg          <= IDLE;
                    mem_read_reg       <= 1'b0;
                    mem_write_reg      <= 1'b0;
                    err_reg[owner_reg] <= 1'b1;
                    wdog_reg           <= wdog_reg + 8'd1;
                end else begin
                    wdog_reg <= wdog_reg + 8'd1;
                end
            end
        end
    end

    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_width = mem_width_reg;
    assign mem_read  = mem_read_reg;
    assign mem_write = mem_write_reg;
    assign busy      = (state_reg == BUSY);
    assign owner     = owner_reg;
    assign cpu_ok    = ok_vec[0];
    assign dma_ok    = ok_vec[1];
    assign cpu_rdata = rdata_vec[0];
    assign dma_rdata = rdata_vec[1];
    assign cpu_err   = err_reg[0];
    assign dma_err   = err_reg[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by a randomized transaction-level run checked
// against a reference model of the arbitration and watchdog rules.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int RUN_MAX = 4;
    localparam int TO      = 8;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [1:0]  cpu_width;
    logic        cpu_read, cpu_write, cpu_ok, cpu_err;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [1:0]  dma_width;
    logic        dma_read, dma_write, dma_ok, dma_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_width;
    logic        mem_read, mem_write, mem_ok;
    logic        busy, owner;

    mem_port_arbiter #(.DMA_RUN_MAX(RUN_MAX), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_width(cpu_width),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_rdata(cpu_rdata), .cpu_ok(cpu_ok), .cpu_err(cpu_err),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_width(dma_width),
        .dma_read(dma_read), .dma_write(dma_write),
        .dma_rdata(dma_rdata), .dma_ok(dma_ok), .dma_err(dma_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_width(mem_width),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .mem_ok(mem_ok),
        .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
    } req_t;

    int   vectors;
    int   miscompares;
    req_t cur [2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        assert (act === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic req_t rand_req();
        req_t r;
        int   k;
        k       = $urandom_range(0, 9);
        r.rd    = (k == 1) || (k >= 2 && k <= 5);
        r.wr    = (k == 1) || (k >= 6);
        r.addr  = $urandom;
        r.wdata = $urandom;
        r.width = 2'($urandom_range(0, 2));
        return r;
    endfunction

    task automatic apply_req();
        cpu_read  = cur[0].rd;   cpu_write = cur[0].wr;
        cpu_addr  = cur[0].addr; cpu_wdata = cur[0].wdata; cpu_width = cur[0].width;
        dma_read  = cur[1].rd;   dma_write = cur[1].wr;
        dma_addr  = cur[1].addr; dma_wdata = cur[1].wdata; dma_width = cur[1].width;
    endtask

    task automatic drive_garbage();
        cpu_read  = 1'($urandom); cpu_write = 1'($urandom);
        dma_read  = 1'($urandom); dma_write = 1'($urandom);
        cpu_addr  = $urandom; cpu_wdata = $urandom; cpu_width = 2'($urandom);
        dma_addr  = $urandom; dma_wdata = $urandom; dma_width = 2'($urandom);
    endtask

    task automatic clear_req();
        cur[0] = '{1'b0, 1'b0, 32'd0, 32'd0, 2'd0};
        cur[1] = '{1'b0, 1'b0, 32'd0, 32'd0, 2'd0};
        apply_req();
    endtask

    // Random-phase variables
    int          streak;
    int          n;
    int          lat;
    logic        to_case, okexp;
    logic        cv, dv, ci, di, dwin, cwin;
    logic [31:0] rd_val;
    req_t        g;
    logic        exp_seq [10];

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        mem_ok = 1'b0;
        mem_rdata = 32'd0;
        clear_req();
        tick();
        tick();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_width", mem_width, 0);
        check("rst_owner", owner, 0);
        check("rst_errs", {cpu_err, dma_err}, 0);
        check("rst_oks", {cpu_ok, dma_ok}, 0);
        rst = 1'b0;
        tick();

        // CPU word read, ok three cycles after the strobe
        cpu_read = 1'b1; cpu_addr = 32'h0300_0010; cpu_width = 2'd2;
        tick();
        check("t1_mem_read", mem_read, 1);
        check("t1_busy", busy, 1);
        check("t1_owner", owner, 0);
        check("t1_mem_addr", mem_addr, 32'h0300_0010);
        check("t1_mem_width", mem_width, 2);
        tick();
        check("t1_no_early_ok", cpu_ok, 0);
        tick();
        tick();
        mem_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF; cpu_read = 1'b0;
        #1;
        check("t1_cpu_ok", cpu_ok, 1);
        check("t1_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("t1_dma_ok", dma_ok, 0);
        check("t1_dma_rdata", dma_rdata, 0);
        tick();
        mem_ok = 1'b0;
        check("t1_busy_drop", busy, 0);
        check("t1_read_drop", mem_read, 0);
        check("t1_ok_drop", cpu_ok, 0);
        check("t1_idle_rdata", cpu_rdata, 0);

        // Continuous contention, 1-cycle acks: D,D,D,D,C,D,D,D,D,C
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        cpu_read = 1'b1; cpu_addr = 32'h0000_1000;
        dma_read = 1'b1; dma_addr = 32'h0000_2000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_busy", busy, 1);
            check($sformatf("t2_owner_%0d", i), owner, exp_seq[i]);
            check("t2_mem_addr", mem_addr, exp_seq[i] ? 32'h0000_2000 : 32'h0000_1000);
            mem_ok = 1'b1;
            if (i == 9) begin
                cpu_read = 1'b0; dma_read = 1'b0;
            end
            #1;
            check("t2_cpu_ok", cpu_ok, !exp_seq[i]);
            check("t2_dma_ok", dma_ok, exp_seq[i]);
            tick();
            mem_ok = 1'b0;
            check("t2_bubble", busy, 0);
        end

        // DMA write, address changes mid-transaction
        dma_write = 1'b1; dma_addr = 32'h0600_0000; dma_wdata = 32'h1234_5678; dma_width = 2'd2;
        tick();
        check("t3_busy", busy, 1);
        check("t3_owner", owner, 1);
        check("t3_mem_write", mem_write, 1);
        check("t3_mem_read", mem_read, 0);
        check("t3_mem_wdata", mem_wdata, 32'h1234_5678);
        dma_addr = 32'h0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t3_addr_held", mem_addr, 32'h0600_0000);
        end
        mem_ok = 1'b1; dma_write = 1'b0;
        #1;
        check("t3_dma_ok", dma_ok, 1);
        check("t3_cpu_ok", cpu_ok, 0);
        check("t3_addr_at_ok", mem_addr, 32'h0600_0000);
        tick();
        mem_ok = 1'b0;
        check("t3_idle", busy, 0);

        // Watchdog timeout
        cpu_read = 1'b1; cpu_addr = 32'h0000_0040;
        tick();
        cpu_read = 1'b0;
        n = 0;
        while (mem_read === 1'b1 && n < 20) begin
            n++;
            check("t4_err_early", cpu_err, 0);
            check("t4_no_ok", cpu_ok, 0);
            tick();
        end
        check("t4_strobe_cycles", n, TO);
        check("t4_cpu_err", cpu_err, 1);
        check("t4_idle", busy, 0);
        check("t4_no_ok_end", cpu_ok, 0);
        tick();
        check("t4_err_pulse", cpu_err, 0);

        // Illegal DMA request alongside a CPU read
        cpu_read = 1'b1; cpu_addr = 32'h0000_0080;
        dma_read = 1'b1; dma_write = 1'b1;
        tick();
        check("t5_dma_err", dma_err, 1);
        check("t5_cpu_err", cpu_err, 0);
        check("t5_owner", owner, 0);
        check("t5_busy", busy, 1);
        check("t5_mem_read", mem_read, 1);
        check("t5_mem_write", mem_write, 0);
        dma_read = 1'b0; dma_write = 1'b0;
        tick();
        check("t5_dma_err_pulse", dma_err, 0);
        check("t5_mem_write_b", mem_write, 0);
        mem_ok = 1'b1; cpu_read = 1'b0;
        #1;
        check("t5_cpu_ok", cpu_ok, 1);
        check("t5_dma_ok", dma_ok, 0);
        tick();
        mem_ok = 1'b0;
        check("t5_mem_write_c", mem_write, 0);

        // Reset during BUSY
        cpu_read = 1'b1; cpu_addr = 32'h0000_00C0;
        tick();
        check("t6_busy", busy, 1);
        tick();
        rst = 1'b1; cpu_read = 1'b0;
        tick();
        rst = 1'b0;
        check("t6_busy_rst", busy, 0);
        check("t6_strobes", {mem_read, mem_write}, 0);
        check("t6_oks", {cpu_ok, dma_ok}, 0);
        check("t6_errs", {cpu_err, dma_err}, 0);
        tick();
        check("t6_errs_after", {cpu_err, dma_err}, 0);
        cpu_read = 1'b1; cpu_addr = 32'h0000_0100;
        tick();
        check("t6_regrant", busy, 1);
        check("t6_regrant_addr", mem_addr, 32'h0000_0100);
        mem_ok = 1'b1; cpu_read = 1'b0;
        #1;
        check("t6_cpu_ok", cpu_ok, 1);
        tick();
        mem_ok = 1'b0;

        // Randomized transactions against the reference model
        streak = 0;
        cur[0] = rand_req();
        cur[1] = rand_req();
        apply_req();
        for (int it = 0; it < 200; it++) begin
            cv   = cur[0].rd ^ cur[0].wr;
            dv   = cur[1].rd ^ cur[1].wr;
            ci   = cur[0].rd & cur[0].wr;
            di   = cur[1].rd & cur[1].wr;
            dwin = dv && (!cv || streak < RUN_MAX);
            cwin = cv && !dwin;
            g    = dwin ? cur[1] : cur[0];
            if (!dv || cwin) streak = 0;
            if (dwin && streak < RUN_MAX) streak++;

            mem_ok = 1'($urandom); mem_rdata = $urandom;
            #1;
            check("r_idle_busy", busy, 0);
            check("r_idle_oks", {cpu_ok, dma_ok}, 0);
            check("r_idle_cpu_rdata", cpu_rdata, 0);
            check("r_idle_dma_rdata", dma_rdata, 0);
            tick();
            mem_ok = 1'b0;
            check("r_cpu_err", cpu_err, ci);
            check("r_dma_err", dma_err, di);
            check("r_grant", busy, dwin | cwin);
            if (!(dwin || cwin)) begin
                cur[0] = rand_req();
                cur[1] = rand_req();
                apply_req();
                continue;
            end
            check("r_owner", owner, dwin);
            drive_garbage();
            to_case = ($urandom_range(0, 7) == 0);
            lat     = to_case ? TO : $urandom_range(1, 3);
            for (int k = 1; k <= lat; k++) begin
                if (k > 1) begin
                    tick();
                    check("r_busy_err", {cpu_err, dma_err}, 0);
                end
                check("r_busy", busy, 1);
                check("r_mem_addr", mem_addr, g.addr);
                check("r_mem_wdata", mem_wdata, g.wdata);
                check("r_mem_width", mem_width, g.width);
                check("r_mem_strobes", {mem_read, mem_write}, {g.rd, g.wr});
                okexp = (k == lat) && !to_case;
                if (k == lat) begin
                    cur[0] = rand_req();
                    cur[1] = rand_req();
                    apply_req();
                end
                rd_val = $urandom;
                mem_rdata = rd_val;
                mem_ok = okexp;
                #1;
                check("r_cpu_ok", cpu_ok, !dwin && okexp);
                check("r_dma_ok", dma_ok, dwin && okexp);
                check("r_cpu_rdata", cpu_rdata, dwin ? 32'd0 : rd_val);
                check("r_dma_rdata", dma_rdata, dwin ? rd_val : 32'd0);
            end
            tick();
            mem_ok = 1'b0;
            check("r_end_busy", busy, 0);
            check("r_end_strobes", {mem_read, mem_write}, 0);
            check("r_end_cpu_err", cpu_err, to_case && !dwin);
            check("r_end_dma_err", dma_err, to_case && dwin);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
